// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution unit: one-hot op codes, FSM states, flag bit positions.
// Optional flag generation is controlled by the ALU_FLAGS_EN macro in the files that import this package.
package alu_pkg;

  localparam logic [6:0] OP_ADD = 7'h01;
  localparam logic [6:0] OP_SUB = 7'h02;
  localparam logic [6:0] OP_AND = 7'h04;
  localparam logic [6:0] OP_OR  = 7'h08;
  localparam logic [6:0] OP_NOT = 7'h10;
  localparam logic [6:0] OP_SHR = 7'h20;
  localparam logic [6:0] OP_SHL = 7'h40;

  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Exactly one bit set; zero and multi-bit fields are illegal ops.
  function automatic logic is_onehot7(input logic [6:0] op);
    return (op != 7'd0) && ((op & (op - 7'd1)) == 7'd0);
  endfunction

endpackage

// File: rtl/alu_if.sv
// Request/response bundle between a requester (master) and the ALU execution unit (slave).
// Handshake: a request transfers on a clk edge where in_valid && in_ready; a result transfers on an edge where out_valid && out_ready.
interface alu_if #(parameter int WIDTH = 16);

  logic             in_valid;
  logic             in_ready;
  logic [7:0]       ctrl;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [2:0]       flags;
  logic             illegal;

  modport master (
    output in_valid, ctrl, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, flags, illegal
  );

  modport slave (
    input  in_valid, ctrl, op_a, op_b, out_ready,
    output in_ready, out_valid, result, flags, illegal
  );

endinterface

// File: rtl/alu_logic_core.sv
// Single-cycle combinational ADD/SUB/AND/OR/NOT datapath; shifts and unknown ops yield zero.
// The carry output exists only when ALU_FLAGS_EN is defined.
module alu_logic_core
  import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [6:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef ALU_FLAGS_EN
    output logic             carry,
`endif
    output logic [WIDTH-1:0] res
);

`ifdef ALU_FLAGS_EN
    logic [WIDTH:0] sum;
`endif

    always_comb begin
        res = '0;
`ifdef ALU_FLAGS_EN
        sum   = '0;
        carry = 1'b0;
`endif
        case (op)
            OP_ADD: begin
`ifdef ALU_FLAGS_EN
                sum   = {1'b0, a} + {1'b0, b};
                res   = sum[WIDTH-1:0];
                carry = sum[WIDTH];
`else
                res = a + b;
`endif
            end
            OP_SUB: begin
                // Carry out of a + ~b + 1 is 1 when no borrow occurs.
`ifdef ALU_FLAGS_EN
                sum   = {1'b0, a} + {1'b0, ~b} + (WIDTH + 1)'(1);
                res   = sum[WIDTH-1:0];
                carry = sum[WIDTH];
`else
                res = a - b;
`endif
            end
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_NOT:  res = ~a;
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: IDLE/SHIFT/DONE FSM, serial 1-bit-per-cycle shifter and registered result/flags/illegal.
// Define ALU_FLAGS_EN to build the {C,N,Z} flag registers; otherwise flags read as constant 0.
module alu_exec_unit
  import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic   clk,
    input  logic   rst_n,
    alu_if.slave   bus,
    output state_t dbg_state
);

    state_t           state;
    logic [WIDTH-1:0] result_q;
    logic             illegal_q;
    logic             out_valid_q;
    logic             in_ready_q;
    logic [3:0]       cnt;
    logic             shift_left;

    logic [6:0]       op;
    logic [3:0]       amt;
    logic             accept;
    logic             legal;
    logic             is_shift;
    logic [WIDTH-1:0] core_res;
    logic [WIDTH-1:0] shifted;

    assign op       = bus.ctrl[6:0];
    assign amt      = bus.op_b[3:0];
    // A disabled request (ctrl[7]=0) is consumed as a NOP and never leaves IDLE.
    assign accept   = in_ready_q && bus.in_valid && bus.ctrl[7];
    assign legal    = is_onehot7(op);
    assign is_shift = (op == OP_SHR) || (op == OP_SHL);
    assign shifted  = shift_left ? (result_q << 1) : (result_q >> 1);

`ifdef ALU_FLAGS_EN
    logic core_c;
    logic shift_out;
    logic [2:0] flags_q;

    assign shift_out = shift_left ? result_q[WIDTH-1] : result_q[0];

    function automatic logic [2:0] mk_flags(input logic c, input logic [WIDTH-1:0] r);
        logic [2:0] f;
        f         = '0;
        f[FLAG_C] = c;
        f[FLAG_N] = r[WIDTH-1];
        f[FLAG_Z] = (r == '0);
        return f;
    endfunction
`endif

    alu_logic_core #(.WIDTH(WIDTH)) u_core (
        .op    (op),
        .a     (bus.op_a),
        .b     (bus.op_b),
`ifdef ALU_FLAGS_EN
        .carry (core_c),
`endif
        .res   (core_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            result_q    <= '0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            cnt         <= 4'd0;
            shift_left  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        in_ready_q <= 1'b0;
                        if (!legal) begin
                            result_q    <= '0;
                            illegal_q   <= 1'b1;
                            out_valid_q <= 1'b1;
                            state       <= ST_DONE;
                        end else if (is_shift) begin
                            result_q   <= bus.op_a;
                            illegal_q  <= 1'b0;
                            cnt        <= amt;
                            shift_left <= (op == OP_SHL);
                            if (amt == 4'd0) begin
                                out_valid_q <= 1'b1;
                                state       <= ST_DONE;
                            end else begin
                                state <= ST_SHIFT;
                            end
                        end else begin
                            result_q    <= core_res;
                            illegal_q   <= 1'b0;
                            out_valid_q <= 1'b1;
                            state       <= ST_DONE;
                        end
                    end
                end
                ST_SHIFT: begin
                    result_q <= shifted;
                    cnt      <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        out_valid_q <= 1'b1;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // in_ready returns only after this edge, giving the one-cycle bubble.
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ALU_FLAGS_EN
    // Illegal ops leave flags untouched; shifts update on the final shift edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else if (state == ST_IDLE && accept && legal) begin
            if (!is_shift) begin
                flags_q <= mk_flags(core_c, core_res);
            end else if (amt == 4'd0) begin
                flags_q <= mk_flags(1'b0, bus.op_a);
            end
        end else if (state == ST_SHIFT && cnt == 4'd1) begin
            flags_q <= mk_flags(shift_out, shifted);
        end
    end

    assign bus.flags = flags_q;
`else
    assign bus.flags = 3'b000;
`endif

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.illegal   = illegal_q;
    assign dbg_state     = state;

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width in bits.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: in_valid  input  1  operation request present.
REQ-005 Port: in_ready  output  1  unit can accept a request.
REQ-006 Port: ctrl  input  8  bit 7 enable; bits 6:0 one-hot op (ADD=0x01, SUB=0x02, AND=0x04, OR=0x08, NOT=0x10, SHR=0x20, SHL=0x40).
REQ-007 Port: op_a  input  WIDTH  first operand; shifted value for SHR/SHL.
REQ-008 Port: op_b  input  WIDTH  second operand; bits 3:0 are the shift amount for SHR/SHL.
REQ-009 Port: out_valid  output  1  result available.
REQ-010 Port: out_ready  input  1  consumer accepts result.
REQ-011 Port: result  output  WIDTH  registered result.
REQ-012 Port: flags  output  3  registered {C,N,Z}.
REQ-013 Port: illegal  output  1  registered; set with a result whose op field was not one-hot.

Function
REQ-014 The unit SHALL be a three-state FSM: IDLE, SHIFT, DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; a request is accepted on a clk edge with in_valid=1 and in_ready=1.
REQ-016 ctrl[7]=0 on acceptance SHALL be a NOP: stay IDLE, no output, result/flags/illegal unchanged.
REQ-017 ADD/SUB/AND/OR/NOT SHALL load result on the accepting edge and enter DONE (out_valid 1 cycle after acceptance).
REQ-018 ADD = op_a+op_b, C = carry out; SUB = op_a+~op_b+1, C = carry out (1 = no borrow); AND/OR/NOT(op_a) with C=0; all modulo 2^WIDTH.
REQ-019 SHR/SHL SHALL load op_a into result and shift amount into a 4-bit counter, then shift 1 bit per cycle in SHIFT (zero fill) until the counter reaches 0, then enter DONE; latency = shift amount + 1 cycles.
REQ-020 Shift amount 0 SHALL go directly to DONE with result=op_a, C=0.
REQ-021 Shift C SHALL equal the last bit shifted out.
REQ-022 Z SHALL be 1 iff final result is 0; N SHALL equal final result[WIDTH-1].
REQ-023 Op field zero or with more than one bit set (ctrl[7]=1) SHALL produce result=0, illegal=1, flags unchanged, entering DONE after 1 cycle; illegal SHALL be 0 for every legal op.
REQ-024 In DONE, out_valid=1 and result/flags/illegal SHALL hold stable until out_ready=1, then return to IDLE on that edge.
REQ-025 out_valid SHALL not depend combinationally on out_ready; no back-to-back acceptance in the cycle DONE is left (one bubble).
REQ-026 in_valid/ctrl/op changes while not in IDLE SHALL be ignored.

Reset
REQ-027 rst_n=0 SHALL asynchronously force state IDLE, result=0, flags=0, illegal=0, out_valid=0, shift counter=0, including mid-shift.
REQ-028 in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Configuration
REQ-029 With ALU_FLAGS_EN defined, flags SHALL be registered and updated per REQ-018..REQ-023.
REQ-030 Without ALU_FLAGS_EN, flags SHALL be constant 0 and no flag registers or carry logic SHALL exist; all other behaviour unchanged.

Structure
REQ-031 Package alu_pkg SHALL hold the seven one-hot op constants, the FSM state encoding, and flag bit indices (C=2, N=1, Z=0).
REQ-032 Single-cycle ADD/SUB/AND/OR/NOT arithmetic SHALL live in one combinational sub-module alu_logic_core; the FSM, shifter and registers stay in alu_exec_unit.

Verification
REQ-033 ADD 0xFFFF+0x0001, ctrl=0x81 -> out_valid after 1 cycle, result=0x0000, flags C=1,N=0,Z=1.
REQ-034 SUB 0x0003-0x0005, ctrl=0x82 -> result=0xFFFE, C=0, N=1, Z=0.
REQ-035 SHL op_a=0x8001, op_b=0x0004, ctrl=0xC0 -> out_valid 5 cycles after acceptance, result=0x0010, C=0; SHR 0x0003 by 1 -> 0x0001, C=1.
REQ-036 ctrl=0x83 (two bits) -> result=0, illegal=1, flags unchanged; ctrl=0x01 (enable 0) -> no out_valid, stays IDLE.
REQ-037 Hold out_ready=0 for 3 cycles after DONE with in_valid=1 -> result stable, in_ready=0, new request not accepted until after out_ready edge.
REQ-038 Assert rst_n=0 during SHL by 15 at cycle 6 -> out_valid=0, result=0, in_ready=1 after release; compile once without ALU_FLAGS_EN -> flags always 0.
